seg7_scan_monitor: RTL and testbench

- Listens to the multiplexed 7-segment bus (segments/anodos) produced by the display driver.
- Recovers the displayed hex digit shown on each of the 8 positions into a 32-bit word.
- Flags complete scan frames, bus errors and a stalled scan.
- Used for on-board loopback self-check of the counter display path, and as a checker in simulation.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_pattern_decode.sv | 22 ++
 rtl/seg7_scan_monitor.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment bus monitor.
// Glyph patterns are active-low {CA,CB,CC,CD,CE,CF,CG}, indexed by hex value.
package seg7_pkg;

  typedef enum logic [1:0] {
    WAIT_CHANGE,
    SETTLE,
    SAMPLE
  } scan_state_t;

  localparam logic [6:0] BLANK_GLYPH = 7'h7F;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern to its hex nibble.
// Patterns outside the glyph table (blank included) report illegal with nibble 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_segments,
  output logic [3:0] o_nibble,
  output logic       o_legal
);

  always_comb begin
    o_nibble = '0;
    o_legal  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (i_segments == GLYPH_TABLE[k]) begin
        o_nibble = 4'(k);
        o_legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Watches a multiplexed 7-segment bus, recovers the shown digits per position
// and reports frame completion, multi-anode bus errors and a stalled scan.
module seg7_scan_monitor
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int N_DIGITS       = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            segments,
  input  logic [N_DIGITS-1:0]   anodos,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  frame_done,
  output logic [7:0]            frame_count,
  output logic                  scan_error,
  output logic                  stale
);

  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int IW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = $clog2(N_DIGITS + 1);
  localparam int AIW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [6:0]            r_seg, r_segPrev;
  logic [N_DIGITS-1:0]   r_an, r_anPrev, r_lastAn;
  scan_state_t           r_state, w_stateNext;
  logic [SW-1:0]         r_settleCnt, w_settleNext;
  logic [IW-1:0]         r_idle;
  logic [N_DIGITS-1:0]   r_seen;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS-1:0]   r_digitValid;
  logic                  r_frameDone;
  logic [7:0]            r_frameCount;
  logic                  r_scanError;
  logic                  r_stale;

  logic [CW-1:0]         w_lowCount;
  logic [AIW-1:0]        w_index;
  logic                  w_blank, w_oneHot, w_multi;
  logic                  w_inChanged;
  logic [3:0]            w_nibble;
  logic                  w_legal;
  logic                  w_sampleOne;

  seg7_pattern_decode u_decode (
    .i_segments(r_seg),
    .o_nibble  (w_nibble),
    .o_legal   (w_legal)
  );

  always_comb begin
    w_lowCount = '0;
    w_index    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!r_an[i]) begin
        w_lowCount = w_lowCount + CW'(1);
        w_index    = AIW'(i);
      end
    end
  end

  assign w_blank     = (w_lowCount == '0);
  assign w_oneHot    = (w_lowCount == CW'(1));
  assign w_multi     = !w_blank && !w_oneHot;
  assign w_inChanged = (r_an != r_anPrev) || (r_seg != r_segPrev);
  assign w_sampleOne = (r_state == SAMPLE) && w_oneHot;

  // Blank anodes abort a settle before the change check, so a digit-off gap never samples.
  always_comb begin
    w_stateNext  = r_state;
    w_settleNext = r_settleCnt;
    unique case (r_state)
      WAIT_CHANGE: begin
        w_settleNext = '0;
        if ((r_an != r_lastAn) && !w_blank) w_stateNext = SETTLE;
      end
      SETTLE: begin
        if (w_blank) begin
          w_stateNext = WAIT_CHANGE;
        end else if (w_inChanged) begin
          w_settleNext = '0;
        end else if (r_settleCnt == SW'(SETTLE_CYCLES - 1)) begin
          w_stateNext = SAMPLE;
        end else begin
          w_settleNext = r_settleCnt + SW'(1);
        end
      end
      SAMPLE:  w_stateNext = WAIT_CHANGE;
      default: w_stateNext = WAIT_CHANGE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_seg        <= BLANK_GLYPH;
      r_segPrev    <= BLANK_GLYPH;
      r_an         <= '1;
      r_anPrev     <= '1;
      r_lastAn     <= '1;
      r_state      <= WAIT_CHANGE;
      r_settleCnt  <= '0;
      r_idle       <= '0;
      r_seen       <= '0;
      r_digits     <= '0;
      r_digitValid <= '0;
      r_frameDone  <= 1'b0;
      r_frameCount <= '0;
      r_scanError  <= 1'b0;
      r_stale      <= 1'b0;
    end else begin
      r_seg       <= segments;
      r_an        <= anodos;
      r_segPrev   <= r_seg;
      r_anPrev    <= r_an;
      r_state     <= w_stateNext;
      r_settleCnt <= w_settleNext;
      r_frameDone <= 1'b0;

      if ((r_state == SAMPLE) && w_multi) r_scanError <= 1'b1;

      if (w_sampleOne) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (w_index == AIW'(i)) begin
            r_digits[4*i +: 4] <= w_nibble;
            r_digitValid[i]    <= w_legal;
            r_seen[i]          <= 1'b1;
          end
        end
        r_lastAn <= r_an;
        r_idle   <= '0;
        r_stale  <= 1'b0;
      end else begin
        if (r_seen == '1) begin
          r_frameDone  <= 1'b1;
          r_frameCount <= r_frameCount + 8'd1;
          r_seen       <= '0;
        end
        // Idle counter saturates at the timeout; crossing it drops the partial frame.
        if (r_idle != IW'(TIMEOUT_CYCLES - 1)) begin
          r_idle <= r_idle + IW'(1);
          if (r_idle == IW'(TIMEOUT_CYCLES - 2)) begin
            r_stale <= 1'b1;
            r_seen  <= '0;
          end
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_digitValid;
  assign frame_done  = r_frameDone;
  assign frame_count = r_frameCount;
  assign scan_error  = r_scanError;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Directed, table-driven bench for seg7_scan_monitor with a short settle and
// timeout so scans, bounce, bus errors, staleness and frame wrap run quickly.
module tb_seg7_scan_monitor;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  localparam logic [6:0] GLY [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  segments;
  logic [7:0]  anodos;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        scan_error;
  logic        stale;

  seg7_scan_monitor #(
    .SETTLE_CYCLES (SETTLE),
    .N_DIGITS      (8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .segments   (segments),
    .anodos     (anodos),
    .digits     (digits),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .scan_error (scan_error),
    .stale      (stale)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  int expPulses = 0;
  int expFrames = 0;
  logic [31:0] expDigits;
  logic [7:0]  expValid;
  logic [7:0]  expSeen;
  logic        expScanErr;

  typedef struct {
    int         pos;
    logic [6:0] seg;
    logic [3:0] nib;
    logic       legal;
  } vec_t;

  vec_t vecs[20];

  always @(negedge clock) if (frame_done) pulseCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_digits"}, digits, expDigits);
    checkOutput({tag, "_valid"}, {24'h0, digit_valid}, {24'h0, expValid});
    checkOutput({tag, "_frame_count"}, {24'h0, frame_count}, {24'h0, 8'(expFrames)});
    checkOutput({tag, "_pulses"}, pulseCount, expPulses);
    checkOutput({tag, "_scan_error"}, {31'h0, scan_error}, {31'h0, expScanErr});
  endtask

  task automatic modelReset();
    expDigits  = '0;
    expValid   = '0;
    expSeen    = '0;
    expFrames  = 0;
    expScanErr = 1'b0;
  endtask

  task automatic modelSample(input int pos, input logic [3:0] nib, input logic legal);
    expDigits[4*pos +: 4] = legal ? nib : 4'h0;
    expValid[pos] = legal;
    expSeen[pos]  = 1'b1;
    if (expSeen == 8'hFF) begin
      expSeen = '0;
      expFrames++;
      expPulses++;
    end
  endtask

  task automatic applyStimulus(input int pos, input logic [6:0] seg, input logic [3:0] nib,
                               input logic legal, input int hold);
    anodos   = ~(8'b1 << pos);
    segments = seg;
    repeat (hold) @(negedge clock);
    modelSample(pos, nib, legal);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      vecs[k].pos   = (k + 1) % 8;
      vecs[k].seg   = GLY[k];
      vecs[k].nib   = 4'(k);
      vecs[k].legal = 1'b1;
    end
    vecs[16] = '{pos: 5, seg: 7'h7F, nib: 4'h0, legal: 1'b0};
    vecs[17] = '{pos: 2, seg: 7'h7E, nib: 4'h0, legal: 1'b0};
    vecs[18] = '{pos: 6, seg: 7'h55, nib: 4'h0, legal: 1'b0};
    vecs[19] = '{pos: 5, seg: 7'h24, nib: 4'h5, legal: 1'b1};

    reset    = 1'b1;
    anodos   = 8'hFF;
    segments = 7'h7F;
    modelReset();
    repeat (3) @(negedge clock);
    checkAll("reset");
    checkOutput("reset_frame_done", {31'h0, frame_done}, 32'h0);
    checkOutput("reset_stale", {31'h0, stale}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Clean scan of positions 0..7 showing 0..7.
    for (int p = 0; p < 8; p++) applyStimulus(p, GLY[p], 4'(p), 1'b1, 20);
    checkOutput("clean_digits_word", digits, 32'h7654_3210);
    checkOutput("clean_valid_word", {24'h0, digit_valid}, 32'h0000_00FF);
    checkOutput("clean_frame_count", {24'h0, frame_count}, 32'h1);
    checkOutput("clean_one_pulse", pulseCount, 1);

    // Exact latency: digits move on the 7th negedge after the drive.
    anodos   = ~8'b1;
    segments = GLY[8];
    repeat (6) @(negedge clock);
    checkOutput("latency_before", digits, 32'h7654_3210);
    @(negedge clock);
    checkOutput("latency_after", digits, 32'h7654_3218);
    repeat (3) @(negedge clock);
    modelSample(0, 4'h8, 1'b1);

    for (int v = 0; v < 20; v++) begin
      applyStimulus(vecs[v].pos, vecs[v].seg, vecs[v].nib, vecs[v].legal, 10);
      checkOutput($sformatf("vec%0d_digits", v), digits, expDigits);
      checkOutput($sformatf("vec%0d_valid", v), {31'h0, digit_valid[vecs[v].pos]}, {31'h0, vecs[v].legal});
    end
    checkAll("table");

    // Bounce on AN3: segments toggle every 2 cycles, then hold F.
    anodos = ~8'b0000_1000;
    for (int t = 0; t < 5; t++) begin
      segments = (t % 2 == 1) ? 7'h4F : 7'h06;
      repeat (2) @(negedge clock);
    end
    checkOutput("bounce_no_sample", digits, expDigits);
    segments = 7'h38;
    repeat (10) @(negedge clock);
    modelSample(3, 4'hF, 1'b1);
    checkOutput("bounce_nibble_F", {28'h0, digits[15:12]}, 32'hF);
    checkAll("bounce");

    // Two anodes low: sticky error, nothing else moves.
    anodos   = 8'b1111_0011;
    segments = GLY[2];
    repeat (20) @(negedge clock);
    expScanErr = 1'b1;
    checkAll("multi");
    for (int p = 0; p < 8; p++) applyStimulus(p, GLY[15-p], 4'(15 - p), 1'b1, 10);
    checkAll("multi_resume");

    // Stop after three positions and let the scan go stale.
    for (int p = 0; p < 3; p++) applyStimulus(p, GLY[p+4], 4'(p + 4), 1'b1, 10);
    repeat (50) @(negedge clock);
    checkOutput("stale_early", {31'h0, stale}, 32'h0);
    repeat (55) @(negedge clock);
    checkOutput("stale_set", {31'h0, stale}, 32'h1);
    expSeen = '0;
    checkAll("stale_retained");
    for (int p = 3; p < 8; p++) applyStimulus(p, GLY[p], 4'(p), 1'b1, 10);
    checkOutput("stale_cleared", {31'h0, stale}, 32'h0);
    checkAll("stale_partial");
    for (int p = 0; p < 3; p++) applyStimulus(p, GLY[p], 4'(p), 1'b1, 10);
    checkAll("stale_frame");

    // Run full frames until the 8-bit frame counter wraps.
    do begin
      for (int p = 0; p < 8; p++) applyStimulus(p, GLY[(p + expFrames) % 16], 4'((p + expFrames) % 16), 1'b1, 9);
      if ((expFrames % 256) == 255) checkOutput("wrap_255", {24'h0, frame_count}, 32'hFF);
    end while ((expFrames % 256) != 0);
    repeat (2) @(negedge clock);
    checkOutput("wrap_zero", {24'h0, frame_count}, 32'h0);
    checkAll("wrap");

    // Reset in the middle of a partial frame.
    applyStimulus(7, GLY[1], 4'h1, 1'b1, 10);
    applyStimulus(5, GLY[2], 4'h2, 1'b1, 10);
    reset = 1'b1;
    @(negedge clock);
    modelReset();
    checkAll("midreset");
    checkOutput("midreset_frame_done", {31'h0, frame_done}, 32'h0);
    checkOutput("midreset_stale", {31'h0, stale}, 32'h0);
    reset = 1'b0;
    for (int p = 0; p < 7; p++) applyStimulus(p, GLY[p+9], 4'(p + 9), 1'b1, 10);
    checkAll("after_reset_partial");
    applyStimulus(7, GLY[3], 4'h3, 1'b1, 10);
    checkAll("after_reset_frame");
    checkOutput("after_reset_count", {24'h0, frame_count}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
